btc_nonce_sequencer: RTL and testbench
======================================

// Module: btc_nonce_sequencer
// PURPOSE
//  Job controller upstream/downstream of the SHA-256 math core: builds each 512-bit block, drives the core and checks results.
//  Per job: midstate of header block 1 (once), then per nonce: block 2 from the midstate, then SHA-256 of the 256-bit digest.
//  Checks each double hash against a target. Stops on first hit, end of nonce range, or abort.
// PARAMETERS
//  SHA_IV   256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19   IV, H0 in [255:224]
//  LEN_HDR  64'd640   bit length field for header block 2
//  LEN_DIG  64'd256   bit length field for the second hash
// PORTS
//  clk                 in   1    clock
//  reset_n             in   1    async active-low reset
//  start               in   1    1-cycle job start; ignored while busy
//  abort               in   1    level; stops the job after the current core op
//  header_in           in   608  header bytes 0..75, byte 0 at [607:600]
//  nonce_start         in   32   first nonce, inclusive
//  nonce_end           in   32   last nonce, inclusive
//  target              in   256  success when dbl hash < target, unsigned
//  busy                out  1    job in progress
//  done                out  1    1-cycle pulse at job end
//  found               out  1    last job hit target; held until next start
//  nonce_out           out  32   winning nonce, else last nonce tried
//  hash_out            out  256  double hash for nonce_out, {H0..H7}
//  core_first_state    out  1    1-cycle start pulse to core
//  core_message_block  out  512  block to core; held stable for the whole core op
//  core_initial_state  out  256  chaining value to core, H0 in [31:0] (word-reversed)
//  core_hash           in   256  core result {H0..H7}, H0 in [255:224]
//  core_valid          in   1    core result valid; core clears it the cycle after start
//  core_status         in   1    core idle
// BEHAVIOUR
//  Reset: outputs 0 (core_message_block/core_initial_state 0). State IDLE, nonce reg 0, midstate 0.
//  Capture: on start in IDLE, latch header_in, nonce_start, nonce_end, target; clear found; busy=1 next cycle.
//  Issue rule: in any *_ISSUE state, core_first_state=1 only if core_status=1, else hold. Then go to *_WAIT.
//  Wait rule: *_WAIT skips the first cycle (core_valid stale), then waits for core_valid=1. No fixed core latency assumed (~66 cycles).
//  States:
//  - IDLE -> MID_ISSUE on start.
//  - MID_ISSUE: block=header[607:96], init=wrev(SHA_IV). MID_WAIT: midstate<=core_hash -> B2_ISSUE.
//  - B2_ISSUE: block={header[95:0], nonce, 32'h80000000, 288'h0, LEN_HDR}, init=wrev(midstate).
//  - B2_WAIT: dig1<=core_hash -> DB_ISSUE.
//  - DB_ISSUE: block={dig1, 32'h80000000, 160'h0, LEN_DIG}, init=wrev(SHA_IV).
//  - DB_WAIT: dig2<=core_hash -> CHECK.
//  - CHECK (1 cycle): nonce_out<=nonce, hash_out<=dig2. Then the first matching case:
//    dig2<target -> found<=1, DONE;  abort -> DONE;  nonce==nonce_end -> DONE;  else nonce<=nonce+1 (mod 2^32), B2_ISSUE.
//  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
//  - wrev(x): swaps the 32-bit word order.
//  Arithmetic:
//  - Nonce increment wraps FFFFFFFF->00000000.
//  - nonce_end<nonce_start is a legal wrapped range.
//  - nonce_start==nonce_end: exactly one nonce.
//  Boundaries:
//  - Abort is sampled only in CHECK or while waiting on the core. An in-flight core op always completes; no partial blocks are issued.
//  - Abort during MID_*: DONE after the midstate op, found=0, nonce_out=nonce_start.
//  - start and abort both high in IDLE: job starts; abort is honoured at the first check point.
//  - Reset mid-job: immediate return to reset values. Any core result is discarded; reset_n is shared with the core.
//  - start during busy: ignored, no effect on latched inputs.
// CONFIGURATION
//  HASH_COUNT_EN defined:
//  - Adds output hash_count [31:0], reset 0, cleared on start.
//  - Increments in CHECK, once per nonce tested; saturates at FFFFFFFF.
//  HASH_COUNT_EN undefined: no port and no counter logic. All other behaviour is identical.
// TESTING
//  1. target=0, nonce 0..4 -> done after 5 CHECKs, found=0, nonce_out=4, 1+2*5=11 core_first_state pulses.
//  2. target=all ones, nonce_start=0x1234 -> found=1 on first CHECK, nonce_out=0x1234, hash_out=SW model SHA256d.
//  3. header_in=80-byte test header, with nonce byte-swapped from the header and target=dbl hash+1 -> found=1; hash_out matches SW model.
//  4. nonce_start=FFFFFFFE, nonce_end=00000001, target=0 -> 4 nonces FFFFFFFE,FFFFFFFF,0,1 then done; HASH_COUNT_EN: hash_count=4.
//  5. abort in 2nd B2_WAIT, target=0 -> core completes, DONE reached without DB_ISSUE, found=0; new start afterwards accepted.
//  6. reset_n low mid DB_WAIT -> all outputs 0 next edge; start while busy -> no restart, latched nonce_end unchanged.

Source files
------------

// File: rtl/btc_nonce_sequencer.sv
// -----------------------------------------------------------------------------
// btc_nonce_sequencer
//
// Job controller wrapped around a SHA-256 compression core. For each job it
// computes the midstate of header block 1 once, then for every nonce in the
// (inclusive, possibly wrapping) range it hashes header block 2 from that
// midstate and hashes the resulting 256-bit digest again. Each double hash is
// compared against the target. The job stops on the first hit, at the end of
// the range, or on abort.
//
// Optional feature: define HASH_COUNT_EN to add the hash_count output, a
// saturating count of nonces tested in the current/last job.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   1-cycle job start (ignored while busy)
//   abort                   level; ends the job after the current core op
//   header_in[607:0]        header bytes 0..75, byte 0 at [607:600]
//   nonce_start/nonce_end   inclusive nonce range
//   target[255:0]           success when double hash < target (unsigned)
//   busy, done              job in progress / 1-cycle end-of-job pulse
//   found                   last job hit the target (held until next start)
//   nonce_out, hash_out     winning nonce (or last tried) and its double hash
//   core_first_state        1-cycle start pulse to the core
//   core_message_block      512-bit block, stable for the whole core op
//   core_initial_state      chaining value, H0 in [31:0] (word-reversed)
//   core_hash               core result {H0..H7}, H0 in [255:224]
//   core_valid, core_status core result valid / core idle
//   hash_count[31:0]        (HASH_COUNT_EN only) nonces tested, saturating
// -----------------------------------------------------------------------------
module btc_nonce_sequencer #(
    parameter logic [255:0] SHA_IV  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19,
    parameter logic [63:0]  LEN_HDR = 64'd640,
    parameter logic [63:0]  LEN_DIG = 64'd256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] header_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [255:0] hash_out,
    output logic         core_first_state,
    output logic [511:0] core_message_block,
    output logic [255:0] core_initial_state,
    input  logic [255:0] core_hash,
    input  logic         core_valid,
    input  logic         core_status
`ifdef HASH_COUNT_EN
    ,
    output logic [31:0]  hash_count
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        MID_ISSUE,
        MID_WAIT,
        B2_ISSUE,
        B2_WAIT,
        DB_ISSUE,
        DB_WAIT,
        CHECK,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [607:0]  header_reg;
    logic [31:0]   nonce_reg;
    logic [31:0]   nonce_end_reg;
    logic [255:0]  target_reg;
    logic [255:0]  midstate_reg;
    logic [255:0]  dig1_reg;
    logic [255:0]  dig2_reg;
    logic          found_reg;
    logic [31:0]   nonce_out_reg;
    logic [255:0]  hash_out_reg;
    logic          wait_first_reg;
    logic          abort_seen_reg;

    logic          waiting;
    logic          wait_done;
    logic          abort_now;
    logic          hit;
    logic          last_nonce;

    // Swap the order of the eight 32-bit words (core expects H0 in [31:0]).
    function automatic logic [255:0] wrev(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*(7-i) +: 32];
        end
        return r;
    endfunction

    assign waiting    = (state_reg == MID_WAIT) || (state_reg == B2_WAIT) || (state_reg == DB_WAIT);
    // core_valid is still high from the previous op during the first wait
    // cycle, so the first cycle after issue is never treated as completion.
    assign wait_done  = !wait_first_reg && core_valid;
    assign abort_now  = abort || abort_seen_reg;
    assign hit        = dig2_reg < target_reg;
    assign last_nonce = nonce_reg == nonce_end_reg;

    // Next state and core-facing outputs
    always_comb begin
        state_next         = state_reg;
        core_first_state   = 1'b0;
        core_message_block = '0;
        core_initial_state = '0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = MID_ISSUE;
            end
            MID_ISSUE, MID_WAIT: begin
                core_message_block = header_reg[607:96];
                core_initial_state = wrev(SHA_IV);
                if (state_reg == MID_ISSUE) begin
                    if (core_status) begin
                        core_first_state = 1'b1;
                        state_next       = MID_WAIT;
                    end
                end else if (wait_done) begin
                    state_next = abort_now ? DONE : B2_ISSUE;
                end
            end
            B2_ISSUE, B2_WAIT: begin
                core_message_block = {header_reg[95:0], nonce_reg, 32'h8000_0000, 288'h0, LEN_HDR};
                core_initial_state = wrev(midstate_reg);
                if (state_reg == B2_ISSUE) begin
                    if (core_status) begin
                        core_first_state = 1'b1;
                        state_next       = B2_WAIT;
                    end
                end else if (wait_done) begin
                    state_next = abort_now ? DONE : DB_ISSUE;
                end
            end
            DB_ISSUE, DB_WAIT: begin
                core_message_block = {dig1_reg, 32'h8000_0000, 160'h0, LEN_DIG};
                core_initial_state = wrev(SHA_IV);
                if (state_reg == DB_ISSUE) begin
                    if (core_status) begin
                        core_first_state = 1'b1;
                        state_next       = DB_WAIT;
                    end
                end else if (wait_done) begin
                    // The double hash is complete; abort is honoured in CHECK
                    // after the result has been evaluated.
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (hit || abort_now || last_nonce) state_next = DONE;
                else                                state_next = B2_ISSUE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            header_reg     <= '0;
            nonce_reg      <= '0;
            nonce_end_reg  <= '0;
            target_reg     <= '0;
            midstate_reg   <= '0;
            dig1_reg       <= '0;
            dig2_reg       <= '0;
            found_reg      <= 1'b0;
            nonce_out_reg  <= '0;
            hash_out_reg   <= '0;
            wait_first_reg <= 1'b0;
            abort_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_first_reg <= core_first_state;

            // Remember an abort that pulses while the core is busy.
            if (state_reg == IDLE)
                abort_seen_reg <= 1'b0;
            else if (waiting && abort)
                abort_seen_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        header_reg    <= header_in;
                        nonce_reg     <= nonce_start;
                        nonce_end_reg <= nonce_end;
                        target_reg    <= target;
                        found_reg     <= 1'b0;
                    end
                end
                MID_WAIT: begin
                    if (wait_done) begin
                        midstate_reg <= core_hash;
                        if (abort_now) nonce_out_reg <= nonce_reg;
                    end
                end
                B2_WAIT: begin
                    if (wait_done) begin
                        dig1_reg <= core_hash;
                        if (abort_now) nonce_out_reg <= nonce_reg;
                    end
                end
                DB_WAIT: begin
                    if (wait_done) dig2_reg <= core_hash;
                end
                CHECK: begin
                    nonce_out_reg <= nonce_reg;
                    hash_out_reg  <= dig2_reg;
                    if (hit)
                        found_reg <= 1'b1;
                    else if (!abort_now && !last_nonce)
                        nonce_reg <= nonce_reg + 32'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef HASH_COUNT_EN
    logic [31:0] hash_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hash_count_reg <= '0;
        else if (state_reg == IDLE && start)
            hash_count_reg <= '0;
        else if (state_reg == CHECK && hash_count_reg != 32'hFFFF_FFFF)
            hash_count_reg <= hash_count_reg + 32'd1;
    end

    assign hash_count = hash_count_reg;
`endif

    assign busy      = state_reg != IDLE;
    assign done      = state_reg == DONE;
    assign found     = found_reg;
    assign nonce_out = nonce_out_reg;
    assign hash_out  = hash_out_reg;

endmodule

// File: tb/tb_btc_nonce_sequencer.sv
module tb_btc_nonce_sequencer;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [607:0] header_in = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic         busy, done, found;
    logic [31:0]  nonce_out;
    logic [255:0] hash_out;
    logic         core_first_state;
    logic [511:0] core_message_block;
    logic [255:0] core_initial_state;
    logic [255:0] core_hash;
    logic         core_valid;
    logic         core_status;
`ifdef HASH_COUNT_EN
    logic [31:0]  hash_count;
`endif

    btc_nonce_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .abort              (abort),
        .header_in          (header_in),
        .nonce_start        (nonce_start),
        .nonce_end          (nonce_end),
        .target             (target),
        .busy               (busy),
        .done               (done),
        .found              (found),
        .nonce_out          (nonce_out),
        .hash_out           (hash_out),
        .core_first_state   (core_first_state),
        .core_message_block (core_message_block),
        .core_initial_state (core_initial_state),
        .core_hash          (core_hash),
        .core_valid         (core_valid),
        .core_status        (core_status)
`ifdef HASH_COUNT_EN
        ,
        .hash_count         (hash_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- SHA-256 (software) ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [255:0] wswap(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*(7-i) +: 32];
        return r;
    endfunction

    // SHA256d of the 80-byte message (76 header bytes + nonce), standard padding.
    function automatic logic [255:0] sha256d(input logic [607:0] hdr, input logic [31:0] n);
        logic [1023:0] m;
        logic [511:0]  d;
        logic [255:0]  h1;
        m  = {hdr, n, 8'h80, 312'h0, 64'd640};
        h1 = sha_compress(sha_compress(IV, m[1023:512]), m[511:0]);
        d  = {h1, 8'h80, 184'h0, 64'd256};
        return sha_compress(IV, d);
    endfunction

    // ---------------- Core model ----------------
    logic [255:0] core_result;
    int core_cnt, st_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_hash   <= '0;
            core_valid  <= 1'b0;
            core_status <= 1'b1;
            core_cnt    <= 0;
            st_cnt      <= 0;
        end else if (core_first_state && core_status) begin
            core_result <= sha_compress(wswap(core_initial_state), core_message_block);
            core_valid  <= 1'b0;
            core_status <= 1'b0;
            core_cnt    <= $urandom_range(2, 7);
        end else begin
            if (core_cnt > 0) begin
                if (core_cnt == 1) begin
                    core_hash  <= core_result;
                    core_valid <= 1'b1;
                    st_cnt     <= $urandom_range(1, 3);
                end
                core_cnt <= core_cnt - 1;
            end
            // Idle is reported a little after the result to exercise issue-hold.
            if (st_cnt > 0) begin
                if (st_cnt == 1) core_status <= 1'b1;
                st_cnt <= st_cnt - 1;
            end
        end
    end

    // ---------------- Scoreboard ----------------
    typedef struct {
        logic         found;
        logic [31:0]  nonce_out;
        logic [255:0] hash_out;
        bit           chk_hash;
        int           pulses;
        int           tested;
    } exp_t;

    exp_t exp_q[$];
    int mon_pulses = 0;
    int job_no = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (start && !busy) mon_pulses = 0;
            if (core_first_state) mon_pulses++;
            if (done) begin
                exp_t x;
                job_no++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no job pending");
                end else begin
                    x = exp_q.pop_front();
                    chk("found", {255'h0, found}, {255'h0, x.found});
                    chk("nonce_out", {224'h0, nonce_out}, {224'h0, x.nonce_out});
                    if (x.chk_hash) chk("hash_out", hash_out, x.hash_out);
                    chk("core_pulses", mon_pulses, x.pulses);
                    chk("busy_at_done", {255'h0, busy}, 256'h1);
`ifdef HASH_COUNT_EN
                    chk("hash_count", {224'h0, hash_count}, x.tested);
`endif
                    $display("job %0d: found=%b nonce_out=%h pulses=%0d hash=%h",
                             job_no, found, nonce_out, mon_pulses, hash_out);
                end
            end
        end
    end

    // ---------------- Stimulus ----------------
    // amode: 0 none, 1 abort raised together with start, 2 abort in the
    // second B2 wait, 3 a second start (different inputs) while busy.
    task automatic run_job(input logic [607:0] hdr, input logic [31:0] s, input logic [31:0] e,
                           input logic [255:0] tgt, input int amode);
        exp_t x;
        logic [31:0] n;
        logic [255:0] h;
        int pc;
        bit got;
        x.found = 1'b0; x.chk_hash = 1'b1; x.tested = 0;
        n = s;
        forever begin
            h = sha256d(hdr, n);
            x.tested++;
            x.nonce_out = n;
            x.hash_out  = h;
            if (h < tgt) begin x.found = 1'b1; break; end
            if (n == e) break;
            n = n + 32'd1;
        end
        x.pulses = 1 + 2 * x.tested;
        if (amode == 1) begin
            x.found = 1'b0; x.nonce_out = s; x.chk_hash = 1'b0; x.pulses = 1; x.tested = 0;
        end else if (amode == 2) begin
            x.found = 1'b0; x.nonce_out = s + 32'd1; x.chk_hash = 1'b0; x.pulses = 4; x.tested = 1;
        end
        exp_q.push_back(x);

        @(posedge clk); #1;
        header_in = hdr; nonce_start = s; nonce_end = e; target = tgt;
        start = 1'b1; abort = (amode == 1);
        @(posedge clk); #1;
        start = 1'b0;
        pc = 0; got = 0;
        for (int c = 0; c < 5000 && !got; c++) begin
            @(negedge clk);
            if (core_first_state) pc++;
            if (amode == 2 && pc == 4) abort = 1'b1;
            if (amode == 3 && c == 8) begin
                start = 1'b1; nonce_end = e + 32'd50; target = '1; header_in = ~hdr; nonce_start = s + 32'd7;
            end
            if (amode == 3 && c == 9) start = 1'b0;
            if (done) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 5000 cycles");
            void'(exp_q.pop_front());
        end
        abort = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_done", {255'h0, busy}, 256'h0);
        chk("done_one_cycle", {255'h0, done}, 256'h0);
    endtask

    function automatic logic [607:0] rand_hdr();
        logic [607:0] r;
        for (int i = 0; i < 19; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        logic [607:0] hdr;
        logic [31:0]  s, e, n3;
        logic [255:0] tgt, h;
        int pc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {255'h0, busy}, 256'h0);
        chk("rst_done", {255'h0, done}, 256'h0);
        chk("rst_found", {255'h0, found}, 256'h0);
        chk("rst_nonce_out", {224'h0, nonce_out}, 256'h0);
        chk("rst_hash_out", hash_out, 256'h0);
        chk("rst_block_zero", {255'h0, core_message_block == 512'h0}, 256'h1);
        chk("rst_init", core_initial_state, 256'h0);
        reset_n = 1'b1;

        // 1: no hit over 0..4
        run_job(rand_hdr(), 32'h0, 32'h4, 256'h0, 0);
        // 2: hit on first nonce
        run_job(rand_hdr(), 32'h1234, 32'h1240, '1, 0);
        // 3: header whose own nonce bytes are byte-swapped into the nonce field
        hdr = rand_hdr();
        n3  = $urandom();
        s   = {n3[7:0], n3[15:8], n3[23:16], n3[31:24]};
        h   = sha256d(hdr, s);
        run_job(hdr, s, s + 32'd3, h + 256'd1, 0);
        // 4: wrapped range
        run_job(rand_hdr(), 32'hFFFF_FFFE, 32'h0000_0001, 256'h0, 0);
        // 5: abort in 2nd B2 wait, then abort with start, then a normal job
        run_job(rand_hdr(), 32'h10, 32'h20, 256'h0, 2);
        run_job(rand_hdr(), 32'h55, 32'h60, 256'h0, 1);
        run_job(rand_hdr(), 32'h7, 32'h7, 256'h0, 0);
        // start while busy must not alter the running job
        run_job(rand_hdr(), 32'h100, 32'h101, 256'h0, 3);

        // Random jobs
        for (int j = 0; j < 8; j++) begin
            int len, mode, k;
            hdr = rand_hdr();
            s   = (j % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom();
            len = $urandom_range(1, 4);
            e   = s + 32'(len - 1);
            mode = $urandom_range(0, 2);
            if (mode == 0) tgt = '0;
            else if (mode == 1) tgt = '1;
            else begin
                k   = $urandom_range(0, len - 1);
                tgt = sha256d(hdr, s + 32'(k)) + 256'd1;
            end
            run_job(hdr, s, e, tgt, 0);
        end

        // 6: reset during the first double-hash wait
        @(posedge clk); #1;
        header_in = rand_hdr(); nonce_start = 32'h0; nonce_end = 32'h9; target = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pc = 0;
        for (int c = 0; c < 3000 && pc < 3; c++) begin
            @(negedge clk);
            if (core_first_state) pc++;
        end
        chk("reached_db_issue", pc, 3);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", {255'h0, busy}, 256'h0);
        chk("midrst_done", {255'h0, done}, 256'h0);
        chk("midrst_nonce_out", {224'h0, nonce_out}, 256'h0);
        chk("midrst_hash_out", hash_out, 256'h0);
        chk("midrst_first_state", {255'h0, core_first_state}, 256'h0);
        chk("midrst_block_zero", {255'h0, core_message_block == 512'h0}, 256'h1);
        chk("midrst_init", core_initial_state, 256'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_job(rand_hdr(), 32'h2, 32'h3, 256'h0, 0);

        chk("scoreboard_empty", exp_q.size(), 256'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
